// File: rtl/rf_wb_sched_if.sv
// rf_wb_sched_if: issue, writeback and RF-write signals of the writeback scheduler.
interface rf_wb_sched_if #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5
);
  logic            issue_valid;
  logic            issue_ready;
  logic [AW-1:0]   issue_rs1;
  logic [AW-1:0]   issue_rs2;
  logic [AW-1:0]   issue_rd;
  logic            issue_rd_wen;
  logic            wb0_valid;
  logic            wb0_ready;
  logic [AW-1:0]   wb0_rd;
  logic [XLEN-1:0] wb0_data;
  logic            wb1_valid;
  logic            wb1_ready;
  logic [AW-1:0]   wb1_rd;
  logic [XLEN-1:0] wb1_data;
  logic [AW-1:0]   rf_waddr;
  logic            rf_wen;
  logic [XLEN-1:0] rf_wdata;
  logic [NREG-1:0] busy_mask;
  logic            sb_err;
  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_wen,
    output wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
    input  issue_ready, wb0_ready, wb1_ready, rf_waddr, rf_wen, rf_wdata, busy_mask, sb_err
  );
  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_wen,
    input  wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
    output issue_ready, wb0_ready, wb1_ready, rf_waddr, rf_wen, rf_wdata, busy_mask, sb_err
  );
endinterface

// File: rtl/rf_wb_sched.sv
// rf_wb_sched: register-file write-port owner; scoreboard issue gating and round-robin writeback arbitration.
// Optional checker enabled by macro RF_SCOREBOARD_CHECK_EN (drives sticky sb_err).
module rf_wb_sched #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input logic         clock,
  input logic         reset,
  rf_wb_sched_if.slave bus
);
  logic [NREG-1:0] pending_q, pending_d;
  logic            last_grant_q, last_grant_d;
  logic            rf_wen_q, rf_wen_d;
  logic [AW-1:0]   rf_waddr_q, rf_waddr_d, grd;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d, gdata;
  logic            g0, g1, gnt, fire;
  // Grants are suppressed while reset is asserted so no transfer is consumed and lost.
  assign g0    = reset && bus.wb0_valid && (!bus.wb1_valid || last_grant_q);
  assign g1    = reset && bus.wb1_valid && (!bus.wb0_valid || !last_grant_q);
  assign gnt   = g0 || g1;
  assign grd   = g1 ? bus.wb1_rd : bus.wb0_rd;
  assign gdata = g1 ? bus.wb1_data : bus.wb0_data;
  assign bus.issue_ready = !pending_q[bus.issue_rs1] && !pending_q[bus.issue_rs2]
                           && !(bus.issue_rd_wen && pending_q[bus.issue_rd]);
  assign fire = bus.issue_valid && bus.issue_ready && bus.issue_rd_wen && (bus.issue_rd != '0);
  assign bus.wb0_ready = g0;
  assign bus.wb1_ready = g1;
  assign bus.rf_wen    = rf_wen_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.busy_mask = pending_q;
  always_comb begin
    pending_d = pending_q;
    if (rf_wen_q) pending_d[rf_waddr_q] = 1'b0;
    if (fire) pending_d[bus.issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
    last_grant_d = g1 ? 1'b1 : g0 ? 1'b0 : last_grant_q;
    rf_wen_d     = gnt && (grd != '0);
    rf_waddr_d   = gnt ? grd : rf_waddr_q;
    rf_wdata_d   = gnt ? gdata : rf_wdata_q;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      pending_q    <= '0;
      last_grant_q <= 1'b1;
      rf_wen_q     <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      rf_wen_q     <= rf_wen_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end
`ifdef RF_SCOREBOARD_CHECK_EN
  logic        sb_err_q, err_gnt, err_dup;
  logic [31:0] cyc_q;
  assign err_gnt = gnt && (grd != '0) && !pending_q[grd];
  assign err_dup = reset && bus.wb0_valid && bus.wb1_valid
                   && (bus.wb0_rd == bus.wb1_rd) && (bus.wb0_rd != '0);
  assign bus.sb_err = sb_err_q;
  always_ff @(posedge clock) begin
    if (!reset) begin
      sb_err_q <= 1'b0;
      cyc_q    <= '0;
    end else begin
      sb_err_q <= sb_err_q || err_gnt || err_dup;
      cyc_q    <= cyc_q + 32'd1;
      if (err_gnt) $display("[rf_wb_sched] cycle %0d: wb%0d writes non-pending rd=%0d", cyc_q, g1 ? 1 : 0, grd);
      if (err_dup) $display("[rf_wb_sched] cycle %0d: wb0/wb1 same rd=%0d", cyc_q, bus.wb0_rd);
    end
  end
`else
  assign bus.sb_err = 1'b0;
`endif
endmodule

// File: tb/tb_rf_wb_sched.sv
// tb_rf_wb_sched: directed self-checking bench for rf_wb_sched.
module tb_rf_wb_sched;
  logic clock;
  logic reset;
  int   tests  = 0;
  int   failed = 0;
`ifdef RF_SCOREBOARD_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif
  rf_wb_sched_if #(.XLEN(64), .NREG(32), .AW(5)) bus ();
  rf_wb_sched #(.XLEN(64), .NREG(32), .AW(5)) dut (.clock(clock), .reset(reset), .bus(bus.slave));
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  initial begin
    reset = 1'b0;
    bus.issue_valid = 0; bus.issue_rs1 = 0; bus.issue_rs2 = 0; bus.issue_rd = 0; bus.issue_rd_wen = 0;
    bus.wb0_valid = 1; bus.wb0_rd = 5'd4; bus.wb0_data = 64'h1;
    bus.wb1_valid = 0; bus.wb1_rd = 0; bus.wb1_data = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_wen", bus.rf_wen, 0);
      chk("rst_busy", bus.busy_mask, 0);
      chk("rst_err", bus.sb_err, 0);
      chk("rst_wb0_ready", bus.wb0_ready, 0);
    end
    reset = 1'b1; bus.wb0_valid = 0;
    // RAW stall on x5 released one cycle after its write
    bus.issue_valid = 1; bus.issue_rd = 5'd5; bus.issue_rd_wen = 1;
    #1 chk("issue5_ready", bus.issue_ready, 1);
    step();
    chk("busy5", bus.busy_mask, 64'h20);
    bus.issue_rs1 = 5'd5; bus.issue_rd = 0; bus.issue_rd_wen = 0;
    #1 chk("raw_stall", bus.issue_ready, 0);
    bus.issue_valid = 0;
    bus.wb0_valid = 1; bus.wb0_rd = 5'd5; bus.wb0_data = 64'hDEAD;
    #1 chk("wb0_grant5", bus.wb0_ready, 1);
    step();
    chk("wen5", bus.rf_wen, 1);
    chk("waddr5", bus.rf_waddr, 5);
    chk("wdata5", bus.rf_wdata, 64'hDEAD);
    bus.wb0_valid = 0; bus.issue_valid = 1;
    #1 chk("bubble_stall", bus.issue_ready, 0);
    step();
    chk("raw_release", bus.issue_ready, 1);
    chk("busy_clear5", bus.busy_mask, 0);
    chk("wen_idle", bus.rf_wen, 0);
    chk("waddr_hold", bus.rf_waddr, 5);
    chk("wdata_hold", bus.rf_wdata, 64'hDEAD);
    bus.issue_valid = 0; bus.issue_rs1 = 0;
    // x0 is never tracked and its writeback is swallowed
    bus.issue_valid = 1; bus.issue_rd = 0; bus.issue_rd_wen = 1;
    step();
    bus.issue_valid = 0;
    chk("busy_x0", bus.busy_mask, 0);
    bus.wb1_valid = 1; bus.wb1_rd = 0; bus.wb1_data = 64'h55;
    #1 chk("wb1_grant_x0", bus.wb1_ready, 1);
    step();
    bus.wb1_valid = 0;
    chk("wen_x0", bus.rf_wen, 0);
    // contention after a wb1 grant: wb0 first
    bus.issue_valid = 1; bus.issue_rd_wen = 1; bus.issue_rd = 5'd3;
    step();
    bus.issue_rd = 5'd7;
    step();
    bus.issue_valid = 0; bus.issue_rd_wen = 0; bus.issue_rd = 0;
    chk("busy_3_7", bus.busy_mask, 64'h88);
    bus.wb0_valid = 1; bus.wb0_rd = 5'd3; bus.wb0_data = 64'h33;
    bus.wb1_valid = 1; bus.wb1_rd = 5'd7; bus.wb1_data = 64'h77;
    #1 chk("cont_wb0_ready", bus.wb0_ready, 1);
    chk("cont_wb1_wait", bus.wb1_ready, 0);
    step();
    chk("cont_wen3", bus.rf_wen, 1);
    chk("cont_waddr3", bus.rf_waddr, 3);
    chk("cont_wdata3", bus.rf_wdata, 64'h33);
    bus.wb0_valid = 0;
    #1 chk("cont_wb1_ready", bus.wb1_ready, 1);
    step();
    chk("cont_waddr7", bus.rf_waddr, 7);
    chk("cont_wdata7", bus.rf_wdata, 64'h77);
    chk("busy_7_only", bus.busy_mask, 64'h80);
    bus.wb1_valid = 0;
    step();
    chk("cont_idle", bus.rf_wen, 0);
    chk("busy_empty", bus.busy_mask, 0);
    // sustained contention alternates starting with wb0
    bus.wb0_valid = 1; bus.wb0_rd = 5'd10; bus.wb1_valid = 1; bus.wb1_rd = 5'd11;
    for (int i = 0; i < 6; i++) begin
      #1 chk("rr_wb0_ready", bus.wb0_ready, (i % 2 == 0) ? 1 : 0);
      chk("rr_wb1_ready", bus.wb1_ready, (i % 2 == 0) ? 0 : 1);
      step();
      chk("rr_wen", bus.rf_wen, 1);
      chk("rr_waddr", bus.rf_waddr, (i % 2 == 0) ? 10 : 11);
    end
    bus.wb0_valid = 0; bus.wb1_valid = 0;
    step();
    chk("rr_idle", bus.rf_wen, 0);
    // write to a register with no pending bit still happens
    bus.wb0_valid = 1; bus.wb0_rd = 5'd9; bus.wb0_data = 64'h99;
    #1 chk("wb0_grant9", bus.wb0_ready, 1);
    step();
    bus.wb0_valid = 0;
    chk("wen9", bus.rf_wen, 1);
    chk("waddr9", bus.rf_waddr, 9);
    chk("wdata9", bus.rf_wdata, 64'h99);
    step();
    chk("sb_err_set", bus.sb_err, EXP_ERR);
    step();
    chk("sb_err_sticky", bus.sb_err, EXP_ERR);
    reset = 1'b0;
    step();
    chk("rst2_err", bus.sb_err, 0);
    chk("rst2_wen", bus.rf_wen, 0);
    chk("rst2_waddr", bus.rf_waddr, 0);
    chk("rst2_wdata", bus.rf_wdata, 0);
    chk("rst2_busy", bus.busy_mask, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
